// File: rtl/pll_ctrl_pkg.sv
// Shared types and default constants for the PLL reset/lock sequencer.
// Contents:
//   pll_state_e  - sequencer state encoding (3 bits)
//   RETRY_W      - width of the failed-attempt counter
//   DEF_*        - default timing constants for a 50 MHz reference clock
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } pll_state_e;

    localparam int RETRY_W          = 4;

    localparam int DEF_NUM_DOMAINS  = 3;
    localparam int DEF_CNT_W        = 20;
    localparam int DEF_RST_HOLD     = 16;
    localparam int DEF_LOCK_STABLE  = 1024;
    localparam int DEF_LOCK_TIMEOUT = 500000;   // 10 ms at 50 MHz
    localparam int DEF_DOMAIN_GAP   = 8;
    localparam int DEF_MAX_RETRY    = 3;

endpackage

// File: rtl/pll_rst_seq_if.sv
// Bundle between the PLL reset sequencer and the PLL / domain reset fabric.
// Signals:
//   pll_locked   - raw PLL locked flag, asynchronous to refclk
//   restart      - single-cycle request to re-run the whole sequence
//   pll_rst      - active-high reset to the PLL
//   domain_rst_n - per-domain active-low resets, bit k gates outclk_k
//   all_ready    - every domain released with the PLL locked
//   lock_lost    - one-cycle pulse when lock drops after qualification
//   fail         - sticky, retry budget exhausted
//   retry_cnt    - failed lock attempts in the current sequence
// Modports: master = sequencer side, slave = PLL / consumer side.
interface pll_rst_seq_if
    import pll_ctrl_pkg::*;
#(
    parameter int NUM_DOMAINS = DEF_NUM_DOMAINS
);
    logic                   pll_locked;
    logic                   restart;
    logic                   pll_rst;
    logic [NUM_DOMAINS-1:0] domain_rst_n;
    logic                   all_ready;
    logic                   lock_lost;
    logic                   fail;
    logic [RETRY_W-1:0]     retry_cnt;

    modport master (
        input  pll_locked, restart,
        output pll_rst, domain_rst_n, all_ready, lock_lost, fail, retry_cnt
    );

    modport slave (
        output pll_locked, restart,
        input  pll_rst, domain_rst_n, all_ready, lock_lost, fail, retry_cnt
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single level signal, reset value 0.
// Ports:
//   clk_i   - destination clock
//   rst_n_i - asynchronous active-low reset
//   d_i     - asynchronous input
//   q_o     - synchronized output (two destination cycles of latency)
module sync_2ff (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/pll_rst_seq.sv
// Reset and lock controller for the 3-output system PLL (50 MHz in).
// Holds the PLL in reset, qualifies its locked flag, then releases the
// per-domain resets in order (outclk_0 first). Lock timeouts re-reset the
// PLL up to MAX_RETRY times; lock loss after qualification re-runs the
// sequence. All outputs are registered.
// Ports:
//   refclk - free-running reference clock, sole clock
//   rst_n  - asynchronous active-low reset
//   bus    - pll_rst_seq_if.master (locked/restart in, resets/status out)
module pll_rst_seq
    import pll_ctrl_pkg::*;
#(
    parameter int NUM_DOMAINS  = DEF_NUM_DOMAINS,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int RST_HOLD     = DEF_RST_HOLD,
    parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int DOMAIN_GAP   = DEF_DOMAIN_GAP,
    parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
    input  logic          refclk,
    input  logic          rst_n,
    pll_rst_seq_if.master bus
);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST     = CNT_W'(DOMAIN_GAP - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

    if ((CNT_W < 1) || (CNT_W > 31) ||
        (longint'(LOCK_TIMEOUT) >= (longint'(1) << CNT_W))) begin : g_chk_timeout
        $error("pll_rst_seq: LOCK_TIMEOUT must be below 2**CNT_W");
    end
    if ((MAX_RETRY < 1) || (MAX_RETRY > 15)) begin : g_chk_retry
        $error("pll_rst_seq: MAX_RETRY must be in 1..15");
    end
    if (NUM_DOMAINS < 1) begin : g_chk_domains
        $error("pll_rst_seq: NUM_DOMAINS must be at least 1");
    end

    pll_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc_s;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [RETRY_W-1:0]     retry_q, retry_d, retry_inc_s;
    logic                   locked_s;
    logic                   loss_s;

    logic                   pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   all_ready_q, all_ready_d;
    logic                   lock_lost_q, lock_lost_d;
    logic                   fail_q, fail_d;

    sync_2ff u_lock_sync (
        .clk_i   (refclk),
        .rst_n_i (rst_n),
        .d_i     (bus.pll_locked),
        .q_o     (locked_s)
    );

    // Shared counter saturates instead of wrapping.
    assign cnt_inc_s   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    assign retry_inc_s = retry_q + RETRY_W'(1);

    // State register: sequencer state, shared counter, release index, retries.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PLL_RST;
            cnt_q   <= '0;
            idx_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
        end
    end

    // Next-state logic; priority is restart, then lock loss, then counter expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc_s;
        idx_d   = idx_q;
        retry_d = retry_q;
        loss_s  = 1'b0;
        if (bus.restart) begin
            state_d = PLL_RST;
            cnt_d   = '0;
            idx_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        state_d = PLL_RST;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_d = retry_inc_s;
                        cnt_d   = '0;
                        if (retry_inc_s == RETRY_LIMIT) begin
                            state_d = FAIL;
                        end else begin
                            state_d = PLL_RST;
                        end
                    end else begin
                        state_d = WAIT_LOCK;
                    end
                end
                STABLE: begin
                    // Any low sample restarts qualification and the timeout window.
                    if (!locked_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        state_d = STABLE;
                    end
                end
                RELEASE: begin
                    // idx_q counts domains already released.
                    if (!locked_s) begin
                        loss_s  = 1'b1;
                        state_d = PLL_RST;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = RUN;
                            idx_d   = '0;
                            retry_d = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        state_d = RELEASE;
                    end
                end
                RUN: begin
                    cnt_d = '0;
                    if (!locked_s) begin
                        loss_s  = 1'b1;
                        state_d = PLL_RST;
                    end else begin
                        state_d = RUN;
                    end
                end
                FAIL: begin
                    cnt_d   = '0;
                    state_d = FAIL;
                end
                default: begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so the registered outputs
    // change on the same edge as the state.
    always_comb begin
        pll_rst_d   = 1'b0;
        dom_d       = '0;
        all_ready_d = 1'b0;
        fail_d      = 1'b0;
        lock_lost_d = loss_s;
        case (state_d)
            PLL_RST: pll_rst_d = 1'b1;
            FAIL: begin
                pll_rst_d = 1'b1;
                fail_d    = 1'b1;
            end
            RELEASE: begin
                for (int k = 0; k < NUM_DOMAINS; k++) begin
                    dom_d[k] = (k < int'(idx_d)) ? 1'b1 : 1'b0;
                end
            end
            RUN: begin
                dom_d       = '1;
                all_ready_d = 1'b1;
            end
            default: pll_rst_d = 1'b0;
        endcase
    end

    // Output registers.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst_q   <= 1'b1;
            dom_q       <= '0;
            all_ready_q <= 1'b0;
            lock_lost_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            pll_rst_q   <= pll_rst_d;
            dom_q       <= dom_d;
            all_ready_q <= all_ready_d;
            lock_lost_q <= lock_lost_d;
            fail_q      <= fail_d;
        end
    end

    assign bus.pll_rst      = pll_rst_q;
    assign bus.domain_rst_n = dom_q;
    assign bus.all_ready    = all_ready_q;
    assign bus.lock_lost    = lock_lost_q;
    assign bus.fail         = fail_q;
    assign bus.retry_cnt    = retry_q;
endmodule

// File: doc/pll_rst_seq.md
Name: pll_rst_seq

Overview:
- Reset and lock controller for the 3-output system PLL: 50 MHz in; 40 / 33.333 / 100 MHz out.
- Runs on the free-running reference clock and drives the PLL's active-high rst.
- Qualifies the asynchronous locked output, then releases per-domain resets in a fixed order (outclk_0 first).
- On lock loss or lock timeout, re-resets the PLL with bounded retries. Sits between the board clock/reset pins and every clock-domain reset synchronizer.

Parameters:
- NUM_DOMAINS, 3, number of sequenced domain resets; bit k gates the outclk_k domain.
- CNT_W, 20, width of the shared cycle counter.
- RST_HOLD, 16, refclk cycles pll_rst is held high per attempt.
- LOCK_STABLE, 1024, consecutive synchronized-locked cycles required before release.
- LOCK_TIMEOUT, 500000, cycles allowed in WAIT_LOCK (10 ms at 50 MHz).
- DOMAIN_GAP, 8, cycles between successive domain releases.
- MAX_RETRY, 3, failed lock attempts before FAIL.

Ports:
- refclk  in  1  reference clock (50 MHz), sole clock.
- rst_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL locked, asynchronous to refclk.
- restart  in  1  single-cycle request to re-run the full sequence.
- pll_rst  out  1  to PLL rst, active high.
- domain_rst_n  out  NUM_DOMAINS  per-domain reset, active low, refclk-registered.
- all_ready  out  1  all domains released, PLL locked.
- lock_lost  out  1  one-cycle pulse on lock loss after qualification.
- fail  out  1  sticky; MAX_RETRY attempts exhausted.
- retry_cnt  out  4  failed attempts in the current sequence.

Behaviour:
- Reset values (async, rst_n low):
  - pll_rst=1, domain_rst_n=0, all_ready=0, lock_lost=0, fail=0, retry_cnt=0.
  - state=PLL_RST, counter=0.
- pll_locked passes through a 2-FF synchronizer to produce locked_s. Only locked_s is used.
- All outputs are registered. No output depends combinationally on any input.
- PLL_RST:
  - pll_rst=1, counter increments.
  - At RST_HOLD-1, go to WAIT_LOCK with counter cleared. pll_rst=0 from that cycle.
- WAIT_LOCK:
  - locked_s=1 → STABLE, counter cleared.
  - Counter reaches LOCK_TIMEOUT-1 → retry_cnt+1. If the new value equals MAX_RETRY → FAIL; otherwise → PLL_RST.
- STABLE:
  - locked_s=0 → WAIT_LOCK, counter cleared (timeout restarts).
  - LOCK_STABLE consecutive high cycles → RELEASE, counter cleared, idx=0.
- RELEASE:
  - Every DOMAIN_GAP cycles, set domain_rst_n[idx]=1 and increment idx. Bits never release out of order.
  - Releasing the last bit → RUN. all_ready=1 in the same cycle as the last bit rises.
- RUN: hold state; retry_cnt cleared on entry.
- Lock loss in RELEASE or RUN (locked_s=0):
  - Next cycle: domain_rst_n=all 0, all_ready=0, lock_lost pulses 1 cycle.
  - Go to PLL_RST. retry_cnt is unchanged by a loss.
- FAIL:
  - fail=1, pll_rst=1 held, domain_rst_n=0.
  - Leave only via restart or rst_n.
- restart (any state, including FAIL):
  - → PLL_RST, counter=0, retry_cnt=0, fail=0, domain_rst_n=0, all_ready=0. No lock_lost pulse.
- Priority: restart > lock loss > counter expiry.
- Timing requirement: with locked_s already stable, domain_rst_n[k] rises exactly LOCK_STABLE+(k+1)*DOMAIN_GAP cycles after the first cycle locked_s=1 is sampled in STABLE.
- Counter saturates at 2^CNT_W-1; it never wraps. Parameter legality: LOCK_TIMEOUT < 2^CNT_W and MAX_RETRY ≤ 15 are checked by elaboration assertions.
- Reset mid-operation: async return to the reset values above. No partial release survives.

Decomposition:
- Package pll_ctrl_pkg:
  - State enum: PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN, FAIL (3-bit).
  - Default timing constants and the retry counter width.
- Sub-module sync_2ff (1-bit, refclk/rst_n, reset value 0) for pll_locked. It is reused by the downstream domain reset synchronizers.

Test Plan:
- Bench parameters for all scenarios: RST_HOLD=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, DOMAIN_GAP=2, MAX_RETRY=2, NUM_DOMAINS=3.
- Nominal: pll_locked held high from reset → pll_rst high 4 cycles; domain_rst_n goes 001, 011, 111 at LOCK_STABLE+2/4/6 cycles after locked_s; all_ready=1 with bit 2; retry_cnt=0.
- Lock glitch: locked_s low for 1 cycle after 5 STABLE cycles → no domain release; the 8-cycle qualification restarts from the next locked_s high.
- Timeout/fail: pll_locked never asserts → retry_cnt=1 after the first 32-cycle window and pll_rst re-pulses 4 cycles; second timeout gives retry_cnt=2, fail=1, pll_rst stuck 1.
- Loss in RUN: drop pll_locked while all_ready=1 → 3 cycles later (2 sync + 1 reg) domain_rst_n=000, all_ready=0, one-cycle lock_lost, pll_rst=1; re-lock gives the same release order.
- restart: pulse in FAIL → fail=0, retry_cnt=0, pll_rst held 4 cycles; pulse during RELEASE at domain_rst_n=011 → 000 next cycle, no lock_lost.
- Async reset: assert rst_n mid-RELEASE → all outputs at reset values immediately, independent of refclk.
